// File: rtl/memoria_instrucao_sinc.sv
// Synchronous-read instruction memory: streamed program load, then valid/ready fetches
// with one-cycle latency, a one-entry output buffer and fault reporting for bad PCs.
module memoria_instrucao_sinc #(
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 32,
    parameter int BYTE_ADDR = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_last,
    output logic              prog_ready,
    output logic              loaded,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instrucao,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [1:0]        instr_fault,
    input  logic              instr_ready
);

    localparam int RA_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_LOAD, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [RA_W-1:0]   wptr_q, wptr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        fault_q, fault_d;
    logic [DATA_W-1:0] instr_q;

    logic [DATA_W-1:0] rom [DEPTH];

    logic              prog_wr;
    logic              fetch_acc;
    logic              wptr_last;
    logic [ADDR_W-1:0] idx;
    logic [RA_W-1:0]   ridx;
    logic              misaligned;
    logic              out_of_range;
    logic [1:0]        fault_new;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (state_q == S_LOAD && prog_wr && (prog_last || wptr_last)) begin
            state_d = S_RUN;
        end
    end

    // Output / handshake logic
    always_comb begin
        prog_ready  = (state_q == S_LOAD);
        loaded      = (state_q == S_RUN);
        fetch_ready = loaded & (~valid_q | instr_ready);
    end

    assign prog_wr   = prog_valid & prog_ready;
    assign fetch_acc = fetch_valid & fetch_ready;
    assign wptr_last = (wptr_q == RA_W'(DEPTH - 1));

    // Range check covers the full PC width so high addresses never alias low words.
    always_comb begin
        idx          = (BYTE_ADDR != 0) ? (fetch_pc >> 2) : fetch_pc;
        ridx         = idx[RA_W-1:0];
        misaligned   = (BYTE_ADDR != 0) && (fetch_pc[1:0] != 2'b00);
        out_of_range = ((idx >> RA_W) != '0) ||
                       ({1'b0, idx[RA_W-1:0]} >= (RA_W+1)'(DEPTH));
        if (misaligned) begin
            fault_new = 2'b01;
        end else if (out_of_range) begin
            fault_new = 2'b10;
        end else begin
            fault_new = 2'b00;
        end
    end

    always_comb begin
        wptr_d  = prog_wr ? wptr_q + 1'b1 : wptr_q;
        pc_d    = fetch_acc ? fetch_pc : pc_q;
        fault_d = fetch_acc ? fault_new : fault_q;
        if (fetch_acc) begin
            valid_d = 1'b1;
        end else if (instr_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            fault_q <= 2'b00;
            instr_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            // Registered read; the output word only changes on an accepted fetch.
            if (fetch_acc) begin
                instr_q <= (fault_new == 2'b00) ? rom[ridx] : '0;
            end
        end
    end

    // Memory contents survive reset; only the load pointer restarts.
    always_ff @(posedge clk) begin
        if (prog_wr && !reset) begin
            rom[wptr_q] <= prog_data;
        end
    end

    assign instr_valid = valid_q;
    assign instrucao   = instr_q;
    assign instr_pc    = pc_q;
    assign instr_fault = fault_q;

endmodule

// File: tb/tb_memoria_instrucao_sinc.sv
// Randomised scoreboard bench for memoria_instrucao_sinc (DEPTH=64, byte addressing).
module tb_memoria_instrucao_sinc;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_valid;
    logic [31:0] prog_data;
    logic        prog_last;
    logic        prog_ready;
    logic        loaded;
    logic        fetch_valid;
    logic [63:0] fetch_pc;
    logic        fetch_ready;
    logic        instr_valid;
    logic [31:0] instrucao;
    logic [63:0] instr_pc;
    logic [1:0]  instr_fault;
    logic        instr_ready;

    memoria_instrucao_sinc #(
        .DEPTH(DEPTH), .ADDR_W(64), .DATA_W(32), .BYTE_ADDR(1)
    ) dut (
        .clk(clk), .reset(reset),
        .prog_valid(prog_valid), .prog_data(prog_data), .prog_last(prog_last),
        .prog_ready(prog_ready), .loaded(loaded),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
        .instr_valid(instr_valid), .instrucao(instrucao), .instr_pc(instr_pc),
        .instr_fault(instr_fault), .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [63:0] pc;
        logic [1:0]  fault;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem_model [DEPTH];
    int          wptr_model = 0;
    bit          loaded_exp = 0;
    bit          mon_en     = 0;
    bit          acc_seen   = 0;
    int          n_checks   = 0;
    int          n_fail     = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: word memory addressed by pc/4, faults decided by plain arithmetic.
    function automatic exp_t model(input logic [63:0] pc);
        exp_t e;
        e.pc = pc;
        e.data = 32'h0;
        if (pc % 4 != 0) begin
            e.fault = 2'b01;
        end else if (pc / 4 >= DEPTH) begin
            e.fault = 2'b10;
        end else begin
            e.fault = 2'b00;
            e.data  = mem_model[pc / 4];
        end
        return e;
    endfunction

    // Monitor: checks handshakes and the buffered result against the scoreboard head.
    always @(negedge clk) begin
        if (mon_en) begin
            bit acc;
            acc = fetch_valid && fetch_ready;
            chk("loaded", loaded, loaded_exp);
            chk("prog_ready", prog_ready, !loaded_exp);
            chk("fetch_ready", fetch_ready, loaded_exp && (sb_q.size() == 0 || instr_ready));
            chk("instr_valid", instr_valid, sb_q.size() != 0);
            if (instr_valid && sb_q.size() != 0) begin
                chk("instrucao", instrucao, sb_q[0].data);
                chk("instr_pc", instr_pc, sb_q[0].pc);
                chk("instr_fault", instr_fault, sb_q[0].fault);
                if (instr_ready) void'(sb_q.pop_front());
            end
            if (acc) sb_q.push_back(model(fetch_pc));
            acc_seen = acc;
        end
    end

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        loaded_exp = 0;
        wptr_model = 0;
        sb_q.delete();
        #1 reset = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        prog_valid = 1'b1;
        prog_data  = d;
        prog_last  = last;
        @(posedge clk);
        if (!loaded_exp) begin
            mem_model[wptr_model] = d;
            if (last || wptr_model == DEPTH - 1) loaded_exp = 1;
            wptr_model++;
        end
        #1;
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        $display("load word=%08h last=%0d loaded_exp=%0d", d, last, loaded_exp);
    endtask

    task automatic do_fetch(input logic [63:0] pc);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        for (int t = 0; ; t++) begin
            @(posedge clk);
            #1;
            if (acc_seen) break;
            if (t >= 50) begin
                chk("fetch_timeout", 1'b0, 1'b1);
                break;
            end
        end
        fetch_valid = 1'b0;
        $display("fetch pc=%016h", pc);
    endtask

    function automatic logic [63:0] rand_pc();
        case ($urandom_range(0, 3))
            0, 1:    return {56'h0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
            2:       return {56'h0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
            default: return {$urandom, $urandom} | 64'h100;
        endcase
    endfunction

    initial begin
        logic [31:0] prog4 [4];
        prog4[0] = 32'h00500093; prog4[1] = 32'h00100113;
        prog4[2] = 32'h002081B3; prog4[3] = 32'h0000006F;

        prog_valid = 0; prog_data = 0; prog_last = 0;
        fetch_valid = 0; fetch_pc = 0; instr_ready = 1;

        do_reset(3);
        mon_en = 1;
        @(negedge clk);
        chk("rst_instrucao", instrucao, 32'h0);
        chk("rst_instr_pc", instr_pc, 64'h0);
        chk("rst_instr_fault", instr_fault, 2'b00);

        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) load_word(prog4[i], i == 3);
        repeat (2) begin @(posedge clk); #1; end

        for (int i = 0; i < 4; i++) do_fetch(64'(i * 4));
        do_fetch(64'd6);
        do_fetch(64'd256);
        do_fetch(64'h8000_0000_0000_0000);
        @(posedge clk); #1;

        // Stall: buffer full, consumer not ready, next request waiting.
        instr_ready = 1'b0;
        do_fetch(64'd4);
        fetch_valid = 1'b1;
        fetch_pc    = 64'd8;
        repeat (3) begin @(posedge clk); #1; end
        instr_ready = 1'b1;
        do_fetch(64'd8);
        @(posedge clk); #1;

        for (int c = 0; c < 300; c++) begin
            if (!fetch_valid || acc_seen) begin
                fetch_valid = ($urandom_range(0, 3) != 0);
                fetch_pc    = rand_pc();
            end
            instr_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        fetch_valid = 1'b0;
        instr_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end

        // Reset while a result is buffered.
        instr_ready = 1'b0;
        do_fetch(64'd0);
        do_reset(1);
        @(negedge clk);
        chk("rr_instr_valid", instr_valid, 1'b0);
        chk("rr_loaded", loaded, 1'b0);
        chk("rr_prog_ready", prog_ready, 1'b1);
        chk("rr_instrucao", instrucao, 32'h0);
        instr_ready = 1'b1;

        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) load_word($urandom, 1'b0);
        load_word(32'hDEAD_BEEF, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < DEPTH; i++) do_fetch(64'(i * 4));
        repeat (3) begin @(posedge clk); #1; end

        @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
